result_drain: RTL and testbench

Reader side of the unified buffer. After the accumulators have written a result matrix into the unified buffer, this block reads it back out and streams it to the host. It walks ROWS×COLS entries row-major from a latched base address and issues one-cycle-latency buffer reads. A 2-entry output buffer lets it present the elements on a valid/ready stream at one element per cycle under backpressure.

---
 rtl/result_drain.sv | 169 ++++++++++++++++
 tb/tb_result_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//
// Reader side of the unified buffer. Once a result matrix of ROWS x COLS
// elements sits in the unified buffer, this block reads it back row-major
// from a latched base address and streams it to the host on a valid/ready
// interface. Buffer reads have one cycle of latency. A 2-entry output FIFO
// lets the block sustain one element per cycle under backpressure.
//
// Parameters:
//   DATA_WIDTH  element width
//   ADDR_WIDTH  unified buffer address width
//   ROWS, COLS  result matrix dimensions (N = ROWS*COLS elements)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   drain request, honoured only in IDLE
//   base_addr  in   address of element (0,0), latched on an accepted start
//   rd_en      out  buffer read strobe
//   rd_addr    out  buffer read address (meaningful while rd_en=1)
//   rd_data    in   buffer read data, valid the cycle after rd_en
//   out_data   out  streamed element (FIFO head)
//   out_valid  out  out_data valid
//   out_ready  in   consumer ready; handshake when out_valid & out_ready
//   out_last   out  marks element N-1, qualified by out_valid
//   busy       out  high while draining (RUN)
//   done       out  one-cycle completion pulse (DONE)
//
// Build option:
//   RESULT_DRAIN_RELU_EN  when defined, out_data is the ReLU of the FIFO head
//                         (head treated as signed); otherwise the raw head.
// -----------------------------------------------------------------------------
module result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int ROWS       = 2,
    parameter int COLS       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] N_CW    = CW'(N);
    localparam logic [CW-1:0] LAST_CW = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [CW-1:0]         r_issue_idx;
    logic [CW-1:0]         r_sent_idx;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_inflight;

    logic [1:0]            w_occupancy;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_head;

    // Occupancy counts both buffered entries and the read whose data lands
    // next cycle, so a newly issued read always has a FIFO slot waiting.
    assign w_occupancy = r_count + {1'b0, r_inflight};
    assign w_pop       = out_valid & out_ready;
    assign w_accept    = (r_state == S_IDLE) && start;

    // A pop in the same cycle frees a slot, so reads resume without a bubble.
    assign w_issue = (r_state == S_RUN) && (r_issue_idx < N_CW) &&
                     ({1'b0, w_occupancy} < (3'd2 + {2'b00, w_pop}));

    assign rd_en   = w_issue;
    assign rd_addr = r_base + ADDR_WIDTH'(r_issue_idx);

    assign w_head    = r_fifo[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign out_last  = (r_sent_idx == LAST_CW) && out_valid;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

`ifdef RESULT_DRAIN_RELU_EN
    assign out_data = w_head[DATA_WIDTH-1] ? '0 : w_head;
`else
    assign out_data = w_head;
`endif

    // NOTE: every always_comb output gets its default first; a path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (start)              w_state_next = S_RUN;
            S_RUN:  if (w_pop && out_last)  w_state_next = S_DONE;
            S_DONE:                         w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the two FIFO entries are reset because out_data must read 0
    // during and after reset; a larger storage array would not be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_issue_idx <= '0;
            r_sent_idx  <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;

            if (w_accept) begin
                r_base      <= base_addr;
                r_issue_idx <= '0;
                r_sent_idx  <= '0;
            end else begin
                if (w_issue) r_issue_idx <= r_issue_idx + 1'b1;
                if (w_pop)   r_sent_idx  <= r_sent_idx + 1'b1;
            end

            // Read data arrives one cycle after the strobe.
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;

            unique case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//
// Directed bench for result_drain (N = 4). A registered buffer model answers
// reads one cycle later. Each drain records a per-cycle trace sampled on the
// falling edge; expectations are hand-computed constants.
// Cycle 0 is the cycle in which start is driven high.
// -----------------------------------------------------------------------------
module tb_result_drain;

    localparam int DW   = 8;
    localparam int AW   = 13;
    localparam int MAXC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          t_rd_en   [MAXC];
    logic [AW-1:0] t_rd_addr [MAXC];
    logic          t_valid   [MAXC];
    logic          t_ready   [MAXC];
    logic [DW-1:0] t_data    [MAXC];
    logic          t_last    [MAXC];
    logic          t_busy    [MAXC];
    logic          t_done    [MAXC];

    logic [DW-1:0] q_out  [$];
    logic [AW-1:0] q_addr [$];

    result_drain #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ROWS      (2),
        .COLS      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Unified buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one drain for ncyc cycles. base_addr is scrambled after cycle 0
    // so any failure to latch it shows up in the address trace.
    task automatic run(input logic [AW-1:0] base, input logic [15:0] stall,
                       input logic [15:0] xstart, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || xstart[c];
            base_addr = (c == 0) ? base : ~base;
            out_ready = !stall[c];
            @(negedge clk);
            t_rd_en[c]   = rd_en;
            t_rd_addr[c] = rd_addr;
            t_valid[c]   = out_valid;
            t_ready[c]   = out_ready;
            t_data[c]    = out_data;
            t_last[c]    = out_last;
            t_busy[c]    = busy;
            t_done[c]    = done;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        q_out.delete();
        q_addr.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (t_valid[c] && t_ready[c]) q_out.push_back(t_data[c]);
            if (t_rd_en[c])               q_addr.push_back(t_rd_addr[c]);
        end
    endtask

    task automatic check_seq(input string tag, input logic [DW-1:0] exp [4]);
        check({tag, " count"}, q_out.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_out.size()) check($sformatf("%s elem%0d", tag, i), q_out[i], exp[i]);
            else                  check($sformatf("%s elem%0d missing", tag, i), 0, 1);
        end
    endtask

    task automatic check_addrs(input string tag, input logic [AW-1:0] exp [4]);
        check({tag, " reads"}, q_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_addr.size()) check($sformatf("%s addr%0d", tag, i), q_addr[i], exp[i]);
            else                   check($sformatf("%s addr%0d missing", tag, i), 0, 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rd_en"},     rd_en,     0);
        check({tag, " rd_addr"},   rd_addr,   0);
        check({tag, " out_data"},  out_data,  0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_last"},  out_last,  0);
        check({tag, " busy"},      busy,      0);
        check({tag, " done"},      done,      0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] e_basic [4];
        logic [DW-1:0] e_wrap  [4];
        logic [DW-1:0] e_relu  [4];
        logic [AW-1:0] a_basic [4];
        logic [AW-1:0] a_wrap  [4];
        int            outst;

        e_basic = '{8'd5, 8'd6, 8'd7, 8'd8};
        e_wrap  = '{8'h11, 8'h22, 8'h33, 8'h44};
        a_basic = '{13'h0010, 13'h0011, 13'h0012, 13'h0013};
        a_wrap  = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
`ifdef RESULT_DRAIN_RELU_EN
        e_relu  = '{8'h00, 8'h00, 8'h7F, 8'h00};
`else
        e_relu  = '{8'h80, 8'hFF, 8'h7F, 8'h00};
`endif

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h0010] = 8'd5;  mem[13'h0011] = 8'd6;
        mem[13'h0012] = 8'd7;  mem[13'h0013] = 8'd8;
        mem[13'h1FFE] = 8'h11; mem[13'h1FFF] = 8'h22;
        mem[13'h0000] = 8'h33; mem[13'h0001] = 8'h44;
        mem[13'h0020] = 8'h80; mem[13'h0021] = 8'hFF;
        mem[13'h0022] = 8'h7F; mem[13'h0023] = 8'h00;

        // ---- power-on reset, checked before the first clock edge ----
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0;
        #3;
        check_outputs_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        step();

        // ---- basic drain: base 0x10, ready held high ----
        run(13'h0010, 16'h0000, 16'h0000, 9);
        for (int c = 0; c < 9; c++) begin
            check($sformatf("basic rd_en c%0d", c), t_rd_en[c], (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4)
                check($sformatf("basic rd_addr c%0d", c), t_rd_addr[c], 13'h0010 + c - 1);
            check($sformatf("basic valid c%0d", c), t_valid[c], (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6)
                check($sformatf("basic data c%0d", c), t_data[c], e_basic[c-3]);
            check($sformatf("basic last c%0d", c), t_last[c], (c == 6));
            check($sformatf("basic busy c%0d", c), t_busy[c], (c >= 1 && c <= 6));
            check($sformatf("basic done c%0d", c), t_done[c], (c == 7));
        end
        check_seq("basic", e_basic);

        // ---- backpressure: out_ready low in cycles 4..6 ----
        run(13'h0010, 16'h0070, 16'h0000, 12);
        for (int c = 4; c <= 6; c++) begin
            check($sformatf("bp hold valid c%0d", c), t_valid[c], 1);
            check($sformatf("bp hold data c%0d", c), t_data[c], 8'd6);
            check($sformatf("bp hold last c%0d", c), t_last[c], 0);
            check($sformatf("bp rd_en low c%0d", c), t_rd_en[c], 0);
        end
        check("bp rd resumes c7", t_rd_en[7], 1);
        check("bp rd_addr c7", t_rd_addr[7], 13'h0013);
        outst = 0;
        for (int c = 0; c < 12; c++) begin
            outst += int'(t_rd_en[c]) - int'(t_valid[c] && t_ready[c]);
            check($sformatf("bp outstanding<=2 c%0d", c), (outst <= 2), 1);
        end
        check("bp last c9", t_last[9], 1);
        check("bp done c9", t_done[9], 0);
        check("bp done c10", t_done[10], 1);
        check_seq("bp", e_basic);

        // ---- address wraparound ----
        run(13'h1FFE, 16'h0000, 16'h0000, 9);
        check_addrs("wrap", a_wrap);
        check_seq("wrap", e_wrap);

        // ---- protocol abuse: start pulsed in RUN (c2) and DONE (c7) ----
        run(13'h0010, 16'h0000, 16'h0084, 10);
        check_addrs("abuse", a_basic);
        check_seq("abuse", e_basic);
        check("abuse done c7", t_done[7], 1);
        check("abuse busy c8", t_busy[8], 0);
        check("abuse busy c9", t_busy[9], 0);

        // ---- reset after element 1's handshake (cycle 4) ----
        for (int c = 0; c < 5; c++) begin
            start     = (c == 0);
            base_addr = 13'h0010;
            out_ready = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                check("abort elem1 valid", out_valid, 1);
                check("abort elem1 data", out_data, 8'd6);
            end
            step();
        end
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("post reset idle");
        step();
        run(13'h0010, 16'h0000, 16'h0000, 9);
        check_addrs("restart", a_basic);
        check_seq("restart", e_basic);
        check("restart first data c3", t_data[3], 8'd5);

        // ---- ReLU data ----
        run(13'h0020, 16'h0000, 16'h0000, 9);
        check_seq("relu", e_relu);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
